// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, byte lanes,
// word size and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam int unsigned WordBytes = 4;

    localparam logic [1:0] Lane0 = 2'd0;
    localparam logic [1:0] Lane1 = 2'd1;
    localparam logic [1:0] Lane2 = 2'd2;
    localparam logic [1:0] Lane3 = 2'd3;

    // Little-endian lane pick, zero-extended to a full word.
    function automatic logic [31:0] lane_zext(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] res;
        res = '0;
        unique case (lane)
            Lane0: res = {24'h0, word[7:0]};
            Lane1: res = {24'h0, word[15:8]};
            Lane2: res = {24'h0, word[23:16]};
            Lane3: res = {24'h0, word[31:24]};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [WordBytes-1:0] lane_mask(input logic [1:0] lane);
        return WordBytes'(1) << lane;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module data_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clock,
    input  logic                           en,
    input  logic [WordBytes-1:0]           be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < WordBytes; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage responder: captures a load/store request, waits LATENCY cycles,
// performs the word/byte RAM access and presents the result in a DONE cycle.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q;
    logic [1:0]        lane_q;
    logic              byte_q, write_q;
    logic [31:0]       wdata_q, rdata_q;
    logic              request, capture, ram_en;
    logic [WordBytes-1:0] ram_be;
    logic [31:0]       ram_wdata, ram_rdata, load_data;

    // Address bits above the word index are intentionally ignored (wrap).
    logic unused_addr;
    assign unused_addr = ^addr[31:IdxW+2];

    assign request = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ram_en  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall = request;
                if (request) begin
                    capture = 1'b1;
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    ram_en  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= Lane0;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= addr[2 +: IdxW];
                lane_q  <= addr[1:0];
                byte_q  <= mem_byte;
                write_q <= mem_write;
                wdata_q <= wdata;
            end
            if (state_q == StDone && !write_q) begin
                rdata_q <= load_data;
            end
        end
    end

    assign ram_be    = !write_q ? '0 : (byte_q ? lane_mask(lane_q) : '1);
    assign ram_wdata = byte_q ? {WordBytes{wdata_q[7:0]}} : wdata_q;

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_data_ram (
        .clock(clock),
        .en   (ram_en),
        .be   (ram_be),
        .idx  (idx_q),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign load_data = byte_q ? lane_zext(ram_rdata, lane_q) : ram_rdata;

    // Loads show the fresh RAM word in DONE; otherwise the last load result is held.
    assign rdata      = (state_q == StDone && !write_q) ? load_data : rdata_q;
    assign misaligned = (state_q == StDone) && !byte_q && (lane_q != Lane0);

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the pipeline's memory stage. It consumes the `mem_read` / `mem_write` / `mem_byte` access flags produced by instruction decode, together with the ALU-computed address and the store data. It performs the word or byte access against an internal word-organised RAM with a fixed, parameterised access latency, and holds the pipeline with `stall` until the access completes.

## Interface
Parameters:
- `DEPTH_WORDS`, default 4096: RAM depth in 32-bit words; must be a power of two.
- `LATENCY`, default 5: BUSY cycles per access; must be at least 1.

Ports:
- `clock`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `mem_read`: input, 1 bit. Load request from decode.
- `mem_write`: input, 1 bit. Store request from decode.
- `mem_byte`: input, 1 bit. Byte access (1) or word access (0).
- `addr`: input, 32 bits. Byte address.
- `wdata`: input, 32 bits. Store data; byte stores use `wdata[7:0]`.
- `rdata`: output, 32 bits. Load result, registered.
- `stall`: output, 1 bit. Pipeline hold request.
- `misaligned`: output, 1 bit. One-cycle pulse flagging a word access with `addr[1:0]` ≠ 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - A request is `mem_read | mem_write`.
  - On a request: capture `addr`, `wdata`, `mem_byte` and the op; load the counter with `LATENCY-1`; go to BUSY.
  - If both flags are set, the write wins and the read is ignored.
  - With no request: stay in IDLE.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter is 0: perform the RAM access at the edge and go to DONE.
  - Inputs are ignored in BUSY; only the captured values are used.
- **DONE**
  - `rdata` is valid for loads.
  - Always returns to IDLE on the next edge, even if request flags are still high. The pipeline advances at that edge, so a later request is the next instruction's.
- **Addressing**
  - Word index = `addr[2 +: log2(DEPTH_WORDS)]`; upper bits are ignored, so addresses wrap modulo the RAM size.
  - Byte lane = `addr[1:0]`, little-endian: lane 0 is bits [7:0].
- **Loads**
  - Word load: `rdata` = the full word.
  - Byte load: `rdata` = the selected lane, zero-extended to 32 bits.
- **Stores**
  - Word store writes all four lanes.
  - Byte store writes only the selected lane, with `wdata[7:0]` replicated onto the lane; other lanes are unchanged.
- **Misaligned word access**
  - `addr[1:0]` is ignored and the aligned word is accessed.
  - `misaligned` = 1 in the DONE cycle only.
- **Stores and `rdata`**: `rdata` holds its previous value.
- **Reset**
  - Reset asserted mid-access returns the FSM to IDLE and clears the counter.
  - A store not yet committed (before the BUSY→DONE edge) is dropped.
  - RAM contents are not reset.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `rdata` = 0, `misaligned` = 0.
  - `stall` = 0, given no request present.
- `stall` (combinational) = (IDLE & request) | BUSY; it is 0 in DONE.
- Request first seen in cycle 0:
  - `stall` is high in cycles 0 through LATENCY, i.e. LATENCY+1 cycles.
  - DONE is cycle LATENCY+1, with `rdata` valid and `stall` = 0.
  - The RAM write commits at the edge ending cycle LATENCY.
- Back-to-back accesses: the earliest next request is accepted in cycle LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- No combinational path from `addr` / `wdata` to `rdata`.

## Structure
- Shared package (`mem_pkg`) holds:
  - the FSM state encoding (IDLE/BUSY/DONE);
  - byte-lane constants;
  - the word-size constant (4 bytes).
- Sub-module `data_ram`: single-port synchronous RAM of 32-bit words with a 4-bit byte-write enable and registered read, `DEPTH_WORDS` deep.
- `data_mem_ctrl` holds the FSM, the counter, the capture registers and the lane select/extend logic.

## Test plan
- **Word store/load**: write 0xDEADBEEF to addr 0x10, then read addr 0x10.
  - Each access has `stall` high for 6 cycles (LATENCY=5).
  - The read's DONE cycle shows `rdata` = 0xDEADBEEF.
- **Byte store/load**:
  - Word 0x00000000 at addr 0x20; byte store 0xAB to 0x22; word read of 0x20 gives 0x00AB0000.
  - Byte read of 0x22 gives 0x000000AB.
  - Byte read of 0x23 gives 0x00000000.
- **Misaligned word read**: word read at 0x13 gives `rdata` = the word at 0x10, with `misaligned` = 1 for exactly the DONE cycle.
- **Wrap-around**: with DEPTH_WORDS=4096, write 0x12345678 to 0x4000; a read of 0x0 gives 0x12345678.
- **Reset mid-store**: start a word store of 0xFFFFFFFF to 0x30 over 0x0; assert reset in BUSY cycle 3; release and read 0x30.
  - The FSM is back in IDLE.
  - `stall` = 0 while reset is asserted.
  - The read returns 0x0.
- **Held request**: keep `mem_read` high across DONE; a second access starts in cycle 7, not cycle 6. Also assert `mem_read` and `mem_write` together: the write is performed.
